// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back arbiter.
//   SEL_*    write-data mux select codes (also the registered indata_sel values)
//   req_e    requester index; its value equals the matching SEL_* code
//   CNT_W    width of the per-requester wait counters
//   NUM_REQ  number of requesters competing for the write port
package wb_pkg;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_DMEM = 2'b01;
    localparam logic [1:0] SEL_DEC  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_DMEM = 2'd1,
        REQ_DEC  = 2'd2
    } req_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: producer handshakes and register-file write port of the
// write-back arbiter.
//   x_valid/x_ready/x_addr/x_data  per producer (alu, dmem, dec)
//   rf_stall                       register file busy
//   rf_we/rf_waddr/rf_wdata        registered write port
//   indata_sel, starved            registered mux select / starvation flag
//   byp_valid/byp_addr/byp_data    grant-cycle forwarding copy (WB_BYPASS_EN only)
// Modports: master = producers/environment, slave = arbiter.
interface wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          alu_valid,  alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          dmem_valid, dmem_ready;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_data;
    logic          dec_valid,  dec_ready;
    logic [AW-1:0] dec_addr;
    logic [DW-1:0] dec_data;
    logic          rf_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [1:0]    indata_sel;
    logic          starved;
`ifdef WB_BYPASS_EN
    logic          byp_valid;
    logic [AW-1:0] byp_addr;
    logic [DW-1:0] byp_data;

    modport master (
        output alu_valid, alu_addr, alu_data, dmem_valid, dmem_addr, dmem_data,
               dec_valid, dec_addr, dec_data, rf_stall,
        input  alu_ready, dmem_ready, dec_ready, rf_we, rf_waddr, rf_wdata,
               indata_sel, starved, byp_valid, byp_addr, byp_data
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, dmem_valid, dmem_addr, dmem_data,
               dec_valid, dec_addr, dec_data, rf_stall,
        output alu_ready, dmem_ready, dec_ready, rf_we, rf_waddr, rf_wdata,
               indata_sel, starved, byp_valid, byp_addr, byp_data
    );
`else
    modport master (
        output alu_valid, alu_addr, alu_data, dmem_valid, dmem_addr, dmem_data,
               dec_valid, dec_addr, dec_data, rf_stall,
        input  alu_ready, dmem_ready, dec_ready, rf_we, rf_waddr, rf_wdata,
               indata_sel, starved
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, dmem_valid, dmem_addr, dmem_data,
               dec_valid, dec_addr, dec_data, rf_stall,
        output alu_ready, dmem_ready, dec_ready, rf_we, rf_waddr, rf_wdata,
               indata_sel, starved
    );
`endif

endinterface

// File: rtl/wb_starve_cnt.sv
// wb_starve_cnt: per-requester saturating wait counter.
//   clk, reset  clock / synchronous active-high reset
//   valid       requester has a pending write
//   grant       requester is accepted this cycle
//   at_max      counter currently equals MAX (requester is promoted)
// Counts every cycle the request waits, saturates at MAX, clears on grant or
// when no request is pending. Keeps counting while the register file stalls.
module wb_starve_cnt
    import wb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    input  logic grant,
    output logic at_max
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || !valid || grant)
            cnt <= '0;
        else if (cnt != CNT_W'(MAX))
            cnt <= cnt + 1'b1;
    end

    assign at_max = (cnt == CNT_W'(MAX));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter for the register-file write port.
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   bus    wb_arbiter_if.slave: ALU / DMEM / DEC handshakes, rf_stall,
//          registered rf_we/rf_waddr/rf_wdata/indata_sel/starved
// One winner per cycle: a requester whose wait counter is at STARVE_MAX goes
// first (ties dmem > alu > dec), otherwise fixed dmem > alu > dec. The write
// appears on the register-file port one cycle after the grant; address 0 is
// accepted but never written.
// Optional macro WB_BYPASS_EN adds byp_valid/byp_addr/byp_data, a
// combinational copy of the winning write in its grant cycle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    wb_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]         vld;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         at_max;
    logic [NUM_REQ-1:0][AW-1:0] addr;
    logic [NUM_REQ-1:0][DW-1:0] data;

    assign vld[REQ_ALU]   = bus.alu_valid;
    assign vld[REQ_DMEM]  = bus.dmem_valid;
    assign vld[REQ_DEC]   = bus.dec_valid;
    assign addr[REQ_ALU]  = bus.alu_addr;
    assign addr[REQ_DMEM] = bus.dmem_addr;
    assign addr[REQ_DEC]  = bus.dec_addr;
    assign data[REQ_ALU]  = bus.alu_data;
    assign data[REQ_DMEM] = bus.dmem_data;
    assign data[REQ_DEC]  = bus.dec_data;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        wb_starve_cnt #(.MAX(STARVE_MAX)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .valid  (vld[i]),
            .grant  (gnt[i]),
            .at_max (at_max[i])
        );
    end

    // at_max is gated with valid so a stale count never wins on its own.
    always_comb begin
        gnt = '0;
        if (!reset && !bus.rf_stall) begin
            if      (vld[REQ_DMEM] && at_max[REQ_DMEM]) gnt[REQ_DMEM] = 1'b1;
            else if (vld[REQ_ALU]  && at_max[REQ_ALU])  gnt[REQ_ALU]  = 1'b1;
            else if (vld[REQ_DEC]  && at_max[REQ_DEC])  gnt[REQ_DEC]  = 1'b1;
            else if (vld[REQ_DMEM])                     gnt[REQ_DMEM] = 1'b1;
            else if (vld[REQ_ALU])                      gnt[REQ_ALU]  = 1'b1;
            else if (vld[REQ_DEC])                      gnt[REQ_DEC]  = 1'b1;
        end
    end

    assign bus.alu_ready  = gnt[REQ_ALU];
    assign bus.dmem_ready = gnt[REQ_DMEM];
    assign bus.dec_ready  = gnt[REQ_DEC];

    // Winner mux; requester index doubles as the data-select code.
    logic [1:0]    win_sel;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic          win_we;

    always_comb begin
        win_sel  = SEL_NONE;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_sel  = 2'(i);
                win_addr = addr[i];
                win_data = data[i];
            end
        end
    end

    // Address 0 is a sink: the handshake completes but nothing is written.
    assign win_we = (win_sel != SEL_NONE) && (win_addr != '0);

    always_ff @(posedge clk) begin
        if (reset || !win_we) begin
            bus.rf_we      <= 1'b0;
            bus.rf_waddr   <= '0;
            bus.rf_wdata   <= '0;
            bus.indata_sel <= SEL_NONE;
        end else begin
            bus.rf_we      <= 1'b1;
            bus.rf_waddr   <= win_addr;
            bus.rf_wdata   <= win_data;
            bus.indata_sel <= win_sel;
        end
        bus.starved <= !reset && (|at_max);
    end

`ifdef WB_BYPASS_EN
    assign bus.byp_valid = win_we;
    assign bus.byp_addr  = win_we ? win_addr : '0;
    assign bus.byp_data  = win_we ? win_data : '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter. Directed scenarios then
// randomized traffic, all checked against a cycle-level reference model of
// the arbitration rules (wait counts, promotion, fixed priority, latency 1).
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int SMAX = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Requester drivers: index 0 = alu, 1 = dmem, 2 = dec.
    logic          v[3];
    logic [AW-1:0] a[3];
    logic [DW-1:0] d[3];

    assign bus.alu_valid  = v[0];
    assign bus.alu_addr   = a[0];
    assign bus.alu_data   = d[0];
    assign bus.dmem_valid = v[1];
    assign bus.dmem_addr  = a[1];
    assign bus.dmem_data  = d[1];
    assign bus.dec_valid  = v[2];
    assign bus.dec_addr   = a[2];
    assign bus.dec_data   = d[2];
    assign bus.rf_stall   = stall;

    // Reference model state.
    int            wt[3];
    int            g_last;
    bit            exp_known;
    logic          exp_we, exp_st;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_sel;

    int            n_chk, n_pass;
    int            wr_log[$];
    logic          obs_we, obs_st;
    logic [1:0]    obs_sel;
    logic [2:0]    obs_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Winner per the rules: promoted requesters first, then dmem > alu > dec.
    function automatic int pick();
        int ord[3] = '{1, 0, 2};
        if (rst || stall) return -1;
        for (int k = 0; k < 3; k++)
            if (v[ord[k]] && wt[ord[k]] == SMAX) return ord[k];
        for (int k = 0; k < 3; k++)
            if (v[ord[k]]) return ord[k];
        return -1;
    endfunction

    // One clock: check at negedge, advance model, return 1 after posedge.
    task automatic cycle();
        int g;
        @(negedge clk);
        g       = pick();
        obs_rdy = {bus.dec_ready, bus.dmem_ready, bus.alu_ready};
        obs_we  = bus.rf_we;
        obs_sel = bus.indata_sel;
        obs_st  = bus.starved;
        for (int i = 0; i < 3; i++)
            chk($sformatf("ready%0d", i), 64'(obs_rdy[i]), 64'(g == i));
        if (exp_known) begin
            chk("rf_we",      64'(obs_we),       64'(exp_we));
            chk("rf_waddr",   64'(bus.rf_waddr), 64'(exp_addr));
            chk("rf_wdata",   64'(bus.rf_wdata), 64'(exp_data));
            chk("indata_sel", 64'(obs_sel),      64'(exp_sel));
            chk("starved",    64'(obs_st),       64'(exp_st));
        end
`ifdef WB_BYPASS_EN
        chk("byp_valid", 64'(bus.byp_valid), 64'(g >= 0 && a[g] != '0));
        if (g >= 0 && a[g] != '0) begin
            chk("byp_addr", 64'(bus.byp_addr), 64'(a[g]));
            chk("byp_data", 64'(bus.byp_data), 64'(d[g]));
        end
`endif
        if (obs_we === 1'b1) wr_log.push_back(int'(bus.rf_waddr));

        exp_st = 1'b0;
        if (!rst)
            for (int i = 0; i < 3; i++) if (wt[i] == SMAX) exp_st = 1'b1;
        if (g >= 0 && a[g] != '0) begin
            exp_we = 1'b1; exp_addr = a[g]; exp_data = d[g]; exp_sel = 2'(g);
        end else begin
            exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_sel = SEL_NONE;
        end
        for (int i = 0; i < 3; i++) begin
            if (rst || !v[i] || g == i) wt[i] = 0;
            else if (wt[i] < SMAX)      wt[i] = wt[i] + 1;
        end
        exp_known = 1'b1;
        g_last    = g;
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        if (g_last >= 0) v[g_last] = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) v[i] = 1'b0;
    endtask

    initial begin
        int n;
        n_chk = 0; n_pass = 0; exp_known = 1'b0; g_last = -1;
        for (int i = 0; i < 3; i++) begin
            wt[i] = 0; v[i] = 1'b1; a[i] = AW'(i + 1); d[i] = $urandom;
        end

        // 1: reset with all valids high
        rst = 1'b1;
        cycle();
        chk("s1_ready", 64'(obs_rdy), 64'(0));
        cycle();
        chk("s1_we", 64'(obs_we), 64'(0));
        chk("s1_sel", 64'(obs_sel), 64'(SEL_NONE));
        clear_all();
        rst = 1'b0;
        cycle();

        // 2: three simultaneous requests -> dmem, alu, dec order
        v[0] = 1'b1; a[0] = 5'd3; d[0] = 32'hAAAA_0001;
        v[1] = 1'b1; a[1] = 5'd4; d[1] = 32'hBBBB_0002;
        v[2] = 1'b1; a[2] = 5'd5; d[2] = 32'hCCCC_0003;
        wr_log.delete();
        for (int k = 0; k < 4; k++) begin
            cycle();
            retire();
        end
        chk("s2_nwr", 64'(wr_log.size()), 64'(3));
        if (wr_log.size() == 3) begin
            chk("s2_wr0", 64'(wr_log[0]), 64'(4));
            chk("s2_wr1", 64'(wr_log[1]), 64'(3));
            chk("s2_wr2", 64'(wr_log[2]), 64'(5));
        end

        // 6: reset the cycle after a grant
        v[0] = 1'b1; a[0] = 5'd9; d[0] = 32'h1234_5678;
        cycle();
        retire();
        rst = 1'b1;
        cycle();
        chk("s6_we_grant", 64'(obs_we), 64'(1));
        rst = 1'b0;
        cycle();
        chk("s6_we_reset", 64'(obs_we), 64'(0));

        // 3: dmem streams, alu waits until promoted
        clear_all();
        v[0] = 1'b1; a[0] = 5'd7; d[0] = 32'h0000_0777;
        v[1] = 1'b1; a[1] = 5'd8; d[1] = $urandom;
        n = 0;
        while (n < 12) begin
            cycle();
            n++;
            if (g_last == 0) break;
            if (g_last == 1) begin a[1] = AW'(8 + n); d[1] = $urandom; end
        end
        chk("s3_alu_cycle", 64'(n), 64'(5));
        v[0] = 1'b0; v[1] = 1'b0;
        cycle();
        chk("s3_starved", 64'(obs_st), 64'(1));
        cycle();
        chk("s3_clear", 64'(obs_st), 64'(0));

        // 4: stall blocks grants, alu wins as soon as it drops
        v[0] = 1'b1; a[0] = 5'd10; d[0] = 32'hDEAD_BEEF;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("s4_no_rdy", 64'(obs_rdy), 64'(0));
        end
        stall = 1'b0;
        cycle();
        chk("s4_grant", 64'(obs_rdy), 64'(3'b001));
        retire();
        cycle();
        chk("s4_write", 64'(obs_we), 64'(1));

        // 5: write to address 0 is accepted but not performed
        v[2] = 1'b1; a[2] = '0; d[2] = 32'hFFFF_FFFF;
        cycle();
        chk("s5_ready", 64'(obs_rdy), 64'(3'b100));
        retire();
        cycle();
        chk("s5_we", 64'(obs_we), 64'(0));
        chk("s5_sel", 64'(obs_sel), 64'(SEL_NONE));

        // Randomized traffic with stalls and occasional reset
        for (int k = 0; k < 400; k++) begin
            retire();
            for (int i = 0; i < 3; i++) begin
                if (!v[i] && ($urandom % 3) != 0) begin
                    v[i] = 1'b1;
                    a[i] = (($urandom % 4) == 0) ? '0 : AW'($urandom);
                    d[i] = $urandom;
                end
            end
            stall = (($urandom % 5) == 0);
            rst   = (($urandom % 40) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
